// File: rtl/rs485_tx_arbiter_if.sv
// Source-side handshake bundle for rs485_tx_arbiter: two byte streams in, per-source grant/ack back.
interface rs485_tx_arbiter_if;
    logic [1:0] req;
    logic [7:0] tx_data0;
    logic [7:0] tx_data1;
    logic [1:0] tx_last;
    logic [1:0] grant;
    logic [1:0] byte_ack;

    modport master (
        output req, tx_data0, tx_data1, tx_last,
        input  grant, byte_ack
    );

    modport slave (
        input  req, tx_data0, tx_data1, tx_last,
        output grant, byte_ack
    );
endinterface

// File: rtl/rs485_tx_arbiter.sv
// Half-duplex RS485 transmitter: round-robin per-frame arbitration between two sources,
// 8N1 serialisation and driver-enable with guard intervals around each frame.
module rs485_tx_arbiter #(
    parameter int GUARD_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        clk_per_bit,
    input  logic              rx_busy,
    rs485_tx_arbiter_if.slave src,
    output logic              Tx,
    output logic              DE,
    output logic              busy,
    output logic              underrun
);

    typedef enum logic [2:0] {IDLE, LEAD, START, DATA, STOP, TRAIL} state_t;

    localparam logic [3:0] GUARD_LAST = 4'(GUARD_BITS - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cpb_q, cpb_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] guard_q, guard_d;
    logic [2:0] bit_q, bit_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic       served_q, served_d;
    logic [1:0] ack_q, ack_d;
    logic       underrun_q, underrun_d;

    logic       bit_end;
    logic       owner_req;
    logic       owner_last;
    logic [7:0] owner_data;
    logic [1:0] owner_onehot;

    assign bit_end      = (cnt_q == cpb_q - 8'd1);
    assign owner_onehot = owner_q ? 2'b10 : 2'b01;
    assign owner_req    = owner_q ? src.req[1] : src.req[0];
    assign owner_last   = owner_q ? src.tx_last[1] : src.tx_last[0];
    assign owner_data   = owner_q ? src.tx_data1 : src.tx_data0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            cpb_q      <= 8'd2;
            shift_q    <= 8'd0;
            guard_q    <= 4'd0;
            bit_q      <= 3'd0;
            last_q     <= 1'b0;
            owner_q    <= 1'b0;
            served_q   <= 1'b1;
            ack_q      <= 2'b00;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpb_q      <= cpb_d;
            shift_q    <= shift_d;
            guard_q    <= guard_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            served_q   <= served_d;
            ack_q      <= ack_d;
            underrun_q <= underrun_d;
        end
    end

    // The cycle counter free-runs through every bit period; states only act on bit_end.
    always_comb begin
        state_d    = state_q;
        cnt_d      = bit_end ? 8'd0 : cnt_q + 8'd1;
        cpb_d      = cpb_q;
        shift_d    = shift_q;
        guard_d    = guard_q;
        bit_d      = bit_q;
        last_d     = last_q;
        owner_d    = owner_q;
        served_d   = served_q;
        ack_d      = 2'b00;
        underrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d   = 8'd0;
                guard_d = 4'd0;
                bit_d   = 3'd0;
                if (!rx_busy && src.req != 2'b00) begin
                    case (src.req)
                        2'b01:   owner_d = 1'b0;
                        2'b10:   owner_d = 1'b1;
                        default: owner_d = ~served_q;
                    endcase
                    cpb_d   = (clk_per_bit < 8'd2) ? 8'd2 : clk_per_bit;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (bit_end) begin
                    if (guard_q == GUARD_LAST) begin
                        guard_d = 4'd0;
                        shift_d = owner_data;
                        last_d  = owner_last;
                        ack_d   = owner_onehot;
                        state_d = START;
                    end else begin
                        guard_d = guard_q + 4'd1;
                    end
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                end
            end
            STOP: begin
                // Back-to-back bytes: the next start bit follows the stop bit directly.
                if (bit_end) begin
                    if (last_q) begin
                        state_d = TRAIL;
                    end else if (owner_req) begin
                        shift_d = owner_data;
                        last_d  = owner_last;
                        ack_d   = owner_onehot;
                        state_d = START;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (bit_end) begin
                    if (guard_q == GUARD_LAST) begin
                        guard_d  = 4'd0;
                        served_d = owner_q;
                        state_d  = IDLE;
                    end else begin
                        guard_d = guard_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            START:   Tx = 1'b0;
            DATA:    Tx = shift_q[0];
            default: Tx = 1'b1;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign DE           = busy;
    assign src.grant    = busy ? owner_onehot : 2'b00;
    assign src.byte_ack = ack_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_rs485_tx_arbiter.sv
// Directed bench for rs485_tx_arbiter: table of frames checked against a waveform model,
// plus hand sequences for tie arbitration, rx hold-off and mid-frame reset.
module tb_rs485_tx_arbiter;

    localparam int GUARD_BITS = 2;
    localparam int FRAME_LIMIT = 3000;

    logic       clk;
    logic       reset;
    logic [7:0] clk_per_bit;
    logic       rx_busy;
    logic       Tx;
    logic       DE;
    logic       busy;
    logic       underrun;

    int assertCount = 0;
    int failCount   = 0;

    rs485_tx_arbiter_if bus ();

    rs485_tx_arbiter #(.GUARD_BITS(GUARD_BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_per_bit (clk_per_bit),
        .rx_busy     (rx_busy),
        .src         (bus.slave),
        .Tx          (Tx),
        .DE          (DE),
        .busy        (busy),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              srcIdx;
        logic [3:0][7:0] bytes;
        int              len;
        bit              finalLast;
        logic [7:0]      cpbIn;
        int              rxBusyAt;
        logic [1:0]      expGrant;
        int              expCpb;
        int              expDeLen;
        int              expUnderruns;
    } frame_vec_t;

    frame_vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected line level k cycles after DE rose, for n bytes at the given bit period.
    function automatic logic expTx(input int k, input int cpb, input logic [3:0][7:0] bytes, input int n);
        int lead;
        int j;
        int idx;
        int pos;
        lead = GUARD_BITS * cpb;
        if (k < lead) return 1'b1;
        j   = k - lead;
        idx = j / (10 * cpb);
        if (idx >= n) return 1'b1;
        pos = (j % (10 * cpb)) / cpb;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return bytes[idx][pos - 1];
    endfunction

    task automatic doReset();
        reset       = 1'b0;
        bus.req     = 2'b00;
        rx_busy     = 1'b0;
        repeat (3) tick();
        checkOutput("rst_Tx", Tx, 1'b1);
        checkOutput("rst_DE", DE, 1'b0);
        checkOutput("rst_grant", bus.grant, 2'b00);
        checkOutput("rst_byte_ack", bus.byte_ack, 2'b00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_underrun", underrun, 1'b0);
        reset = 1'b1;
        tick();
    endtask

    // Runs one frame from vecs[idx], playing the source side, and checks it against the model.
    task automatic applyStimulus(input int idx);
        frame_vec_t v;
        int k;
        int lead;
        int acks;
        int ackPos [8];
        int ackBad;
        int grantBad;
        int txBad;
        int undCount;
        int undPos;
        int posBad;
        v        = vecs[idx];
        lead     = GUARD_BITS * v.expCpb;
        acks     = 0;
        ackBad   = 0;
        grantBad = 0;
        txBad    = 0;
        undCount = 0;
        undPos   = -1;
        posBad   = 0;

        clk_per_bit = v.cpbIn;
        rx_busy     = 1'b0;
        if (v.srcIdx == 0) bus.tx_data0 = v.bytes[0];
        else               bus.tx_data1 = v.bytes[0];
        bus.tx_last[v.srcIdx] = (v.len == 1) ? v.finalLast : 1'b0;
        bus.req[v.srcIdx]     = 1'b1;
        tick();
        checkOutput($sformatf("v%0d_grant_start", idx), bus.grant, v.expGrant);

        k = 0;
        while (DE === 1'b1 && k < FRAME_LIMIT) begin
            if (Tx !== expTx(k, v.expCpb, v.bytes, v.len)) txBad++;
            if (bus.grant !== v.expGrant) grantBad++;
            if (bus.byte_ack !== 2'b00) begin
                if (bus.byte_ack !== v.expGrant) ackBad++;
                if (acks < 8) ackPos[acks] = k;
                acks++;
                if (acks < v.len) begin
                    if (v.srcIdx == 0) bus.tx_data0 = v.bytes[acks];
                    else               bus.tx_data1 = v.bytes[acks];
                    bus.tx_last[v.srcIdx] = (acks == v.len - 1) ? v.finalLast : 1'b0;
                end else begin
                    bus.req[v.srcIdx] = 1'b0;
                end
            end
            if (underrun === 1'b1) begin
                undCount++;
                undPos = k;
            end
            if (k == v.rxBusyAt) rx_busy = 1'b1;
            tick();
            k++;
        end

        for (int i = 0; i < acks && i < v.len && i < 8; i++)
            if (ackPos[i] != lead + i * 10 * v.expCpb) posBad++;

        checkOutput($sformatf("v%0d_timeout", idx), (k >= FRAME_LIMIT), 1'b0);
        checkOutput($sformatf("v%0d_tx_wave_errors", idx), txBad, 0);
        checkOutput($sformatf("v%0d_grant_hold_errors", idx), grantBad, 0);
        checkOutput($sformatf("v%0d_de_cycles", idx), k, v.expDeLen);
        checkOutput($sformatf("v%0d_ack_count", idx), acks, v.len);
        checkOutput($sformatf("v%0d_ack_wrong_src", idx), ackBad, 0);
        checkOutput($sformatf("v%0d_ack_timing_errors", idx), posBad, 0);
        checkOutput($sformatf("v%0d_underrun_count", idx), undCount, v.expUnderruns);
        if (v.expUnderruns != 0)
            checkOutput($sformatf("v%0d_underrun_pos", idx), undPos, lead + 10 * v.len * v.expCpb);
        checkOutput($sformatf("v%0d_end_grant", idx), bus.grant, 2'b00);
        checkOutput($sformatf("v%0d_end_busy", idx), busy, 1'b0);
        rx_busy = 1'b0;
    endtask

    initial begin
        logic [1:0] tieOrder [3];
        logic [1:0] seenGrant;
        int         bad;
        int         w;

        // srcIdx, bytes, len, finalLast, cpbIn, rxBusyAt, expGrant, expCpb, expDeLen, expUnderruns
        vecs[0] = '{0, 32'h000000A5, 1, 1'b1, 8'd4, -1, 2'b01, 4,  56, 0};
        vecs[1] = '{1, 32'h0000003C, 1, 1'b1, 8'd3, -1, 2'b10, 3,  42, 0};
        vecs[2] = '{0, 32'h00000000, 1, 1'b1, 8'd1, -1, 2'b01, 2,  28, 0};
        vecs[3] = '{1, 32'h00000081, 1, 1'b1, 8'd0, -1, 2'b10, 2,  28, 0};
        vecs[4] = '{1, 32'h00030201, 3, 1'b1, 8'd4, -1, 2'b10, 4, 136, 0};
        vecs[5] = '{0, 32'h0000005A, 1, 1'b0, 8'd4, -1, 2'b01, 4,  56, 1};
        vecs[6] = '{0, 32'h0000FFC3, 2, 1'b1, 8'd5, 30, 2'b01, 5, 120, 0};
        vecs[7] = '{0, 32'h00000077, 1, 1'b1, 8'd4, 20, 2'b01, 4,  56, 0};
        vecs[8] = '{1, 32'h00000096, 1, 1'b1, 8'd4, -1, 2'b10, 4,  56, 0};

        clk_per_bit  = 8'd4;
        rx_busy      = 1'b0;
        bus.req      = 2'b00;
        bus.tx_data0 = 8'h00;
        bus.tx_data1 = 8'h00;
        bus.tx_last  = 2'b00;
        doReset();

        // Tie from reset: both sources held requesting single-byte frames.
        tieOrder[0] = 2'b01;
        tieOrder[1] = 2'b10;
        tieOrder[2] = 2'b01;
        bus.tx_data0 = 8'h11;
        bus.tx_data1 = 8'h22;
        bus.tx_last  = 2'b11;
        bus.req      = 2'b11;
        for (int f = 0; f < 3; f++) begin
            w = 0;
            while (DE !== 1'b1 && w < 200) begin
                tick();
                w++;
            end
            checkOutput($sformatf("tie%0d_de_rise", f), DE, 1'b1);
            seenGrant = bus.grant;
            checkOutput($sformatf("tie%0d_grant", f), seenGrant, tieOrder[f]);
            bad = 0;
            w   = 0;
            while (DE === 1'b1 && w < 200) begin
                if (bus.grant !== seenGrant || $countones(bus.grant) != 1) bad++;
                tick();
                w++;
            end
            if (f == 2) bus.req = 2'b00;
            checkOutput($sformatf("tie%0d_grant_onehot_errors", f), bad, 0);
            checkOutput($sformatf("tie%0d_de_gap", f), DE, 1'b0);
        end
        bus.tx_last = 2'b00;
        repeat (4) tick();
        checkOutput("tie_quiet_after", DE, 1'b0);

        for (int i = 0; i < 7; i++)
            applyStimulus(i);

        // Receive side busy: a pending request must wait.
        bus.tx_data0 = 8'h77;
        bus.tx_last  = 2'b01;
        bus.req      = 2'b01;
        rx_busy      = 1'b1;
        clk_per_bit  = 8'd4;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.grant !== 2'b00 || DE !== 1'b0 || busy !== 1'b0) bad++;
        end
        checkOutput("holdoff_errors", bad, 0);
        applyStimulus(7);

        // Reset during DATA bit 3 of a frame from source 0.
        bus.tx_data0 = 8'hA5;
        bus.tx_last  = 2'b01;
        clk_per_bit  = 8'd4;
        bus.req      = 2'b01;
        tick();
        repeat (25) tick();
        checkOutput("midrst_pre_DE", DE, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_Tx", Tx, 1'b1);
        checkOutput("midrst_DE", DE, 1'b0);
        checkOutput("midrst_grant", bus.grant, 2'b00);
        checkOutput("midrst_busy", busy, 1'b0);
        bus.req = 2'b00;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        applyStimulus(8);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/rs485_tx_arbiter.md
# rs485_tx_arbiter

Half-duplex RS485 transmit controller that shares the single line driver between two response sources (e.g. command ACK/echo and telemetry). It arbitrates round-robin per frame and holds off while the receive side is busy. It serializes the granted source's bytes as 8N1 UART at the same `clk_per_bit` rate used by the command receiver, and drives the transceiver driver-enable with guard intervals around each frame.

## Interface
Parameters:
- `GUARD_BITS`, default 2: bit periods of DE-asserted idle (Tx=1) before the first start bit and after the last stop bit.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `clk_per_bit`  in  8  clock cycles per UART bit. Latched at frame start. Values < 2 are treated as 2.
- `rx_busy`  in  1  receive path mid-frame; blocks starting a new frame.
- `req`  in  2  per-source request. Held high while the source has bytes.
- `tx_data0`, `tx_data1`  in  8  current byte of source 0 / 1.
- `tx_last`  in  2  per-source flag: the presented byte is the frame's last.
- `grant`  out  2  one-hot owner of the line for the whole frame.
- `byte_ack`  out  2  one-cycle pulse: byte and last flag of the granted source were latched. The source presents the next byte from the following cycle.
- `Tx`  out  1  serial data; idle high.
- `DE`  out  1  RS485 driver enable.
- `busy`  out  1  high in any state other than IDLE.
- `underrun`  out  1  one-cycle pulse when a frame is aborted for lack of data.

## Operation
- States: IDLE, LEAD, START, DATA, STOP, TRAIL.
- IDLE:
  - Tx=1, DE=0, grant=0.
  - If `rx_busy`=0 and `req`≠0: pick the winner, latch the effective `clk_per_bit`, set grant, then go to LEAD.
- Arbitration is round-robin:
  - Only one requester: it wins.
  - Both requesters: the source not served last wins.
  - After reset, "last served" = source 1, so source 0 wins the first tie.
- LEAD: DE=1, Tx=1 for GUARD_BITS×cpb cycles. Then go to START and latch the first byte.
- Byte latch, on entry to START:
  - shift reg ← `tx_data[g]`, last_q ← `tx_last[g]`.
  - Pulse `byte_ack[g]`.
- START: Tx=0 for cpb cycles.
- DATA: 8 bits, LSB first, each cpb cycles. 3-bit bit index.
- STOP: Tx=1 for cpb cycles. At the end of STOP:
  - last_q=1 → TRAIL.
  - else `req[g]`=1 → START, latch the next byte with no idle gap.
  - else → pulse `underrun`, go to TRAIL.
- TRAIL: DE=1, Tx=1 for GUARD_BITS×cpb cycles. Then go to IDLE and update "last served" ← g.
- `rx_busy` is ignored once past IDLE: the frame is never interrupted.
- Changes to `req` of the non-granted source have no effect until IDLE.
- Changes to `clk_per_bit` mid-frame have no effect.
- Counters: 8-bit cycle counter, 0..cpb−1. Guard counter counts GUARD_BITS bit periods.
- Width: GUARD_BITS ≤ 15; guard bit counter is 4 bits.

## Timing
- Reset (asynchronous, immediate, any state):
  - Tx=1, DE=0, grant=0, byte_ack=0, busy=0, underrun=0.
  - State IDLE, all counters 0, last served = 1.
- Request to DE:
  - `req` sampled high in IDLE at cycle N → grant, DE and busy high from cycle N+1.
  - First start-bit falling edge on Tx at N+1+GUARD_BITS×cpb.
- Per byte: exactly 10×cpb cycles, start edge to next start edge.
- `byte_ack` occurs in the first cycle of START.
- DE deasserts, and grant/busy clear, in the same cycle: the first IDLE cycle after TRAIL.
- At least one IDLE cycle always separates frames. DE=0 for ≥1 cycle between frames.
- Total DE-high time for an n-byte frame: (2×GUARD_BITS + 10n)×cpb cycles.

## Test plan
- **Single byte:** GUARD_BITS=2, cpb=4, req0=1, tx_data0=0xA5, last=1.
  - grant=01 one cycle after req.
  - Tx: 8 high, 4 low, bits 1,0,1,0,0,1,0,1 (4 cycles each), 4 high.
  - Trail 8; DE high for exactly 56 cycles; one byte_ack[0].
- **Tie from reset:** req=11 held, both sources single-byte.
  - Frame order: source 0, source 1, source 0.
  - grant never two-hot; DE low ≥1 cycle between frames.
- **Multi-byte:** source 1 sends 0x01, 0x02, 0x03 (last on 0x03), cpb=4.
  - Three byte_ack[1] pulses, 40 cycles apart.
  - Stop bit followed directly by start bit; DE high (4+30)×4=136 cycles.
- **RX hold-off:** rx_busy=1 with req0 pending for 100 cycles.
  - grant=0, DE=0 throughout.
  - rx_busy falls at cycle M → grant=01 at M+1.
  - rx_busy re-asserted mid-frame: no effect on Tx.
- **Underrun:** source 0 drops req after the first byte with last=0.
  - One underrun pulse at the end of STOP.
  - Then TRAIL of GUARD_BITS×cpb cycles, then DE=0; no second byte_ack.
- **Reset mid-frame:** assert reset during DATA bit 3.
  - Same cycle, combinationally: Tx=1, DE=0, grant=0, busy=0.
  - After release with req1 only: a clean new frame granted to source 1.
